// File: rtl/tl_arb_pkg.sv
// rtl/tl_arb_pkg.sv - shared types, defaults and round-robin helper for TileLink arbiters
package tl_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam logic [0:0] ST_IDLE   = ARB_IDLE;
  localparam logic [0:0] ST_LOCKED = ARB_LOCKED;

  // Explicit compare so non-power-of-two requester counts wrap correctly.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_valid,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_pick,
  output logic         o_any_valid
);

  // Scan offsets high to low so the lowest offset from i_ptr has the final say.
  always_comb begin
    int v_idx;
    v_idx  = 0;
    o_pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      v_idx = int'(i_ptr) + k;
      if (v_idx >= N) v_idx = v_idx - N;
      if (i_valid[v_idx]) o_pick = W'(v_idx);
    end
  end

  assign o_any_valid = |i_valid;

endmodule

// File: rtl/tl_fifo_wr_arbiter.sv
// rtl/tl_fifo_wr_arbiter.sv - burst-locked round-robin arbiter for one FIFO write port
// Optional burst-length limit enabled by defining ARB_BURST_CHK_EN.
module tl_fifo_wr_arbiter
  import tl_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = 8,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy,
  output logic                          burst_err
);

  logic [0:0]          r_state;
  logic [ID_WIDTH-1:0] r_rr_ptr;
  logic [ID_WIDTH-1:0] r_grant;

  logic [ID_WIDTH-1:0] w_pick;
  logic                w_any_valid;
  logic                w_open;
  logic                w_accept;
  logic                w_end;
  logic [ID_WIDTH-1:0] w_next_ptr;

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_WIDTH)
  ) u_rr_pick (
    .i_valid     (req_valid),
    .i_ptr       (r_rr_ptr),
    .o_pick      (w_pick),
    .o_any_valid (w_any_valid)
  );

  // Reset gates the port so an interrupted burst never writes on the reset edge.
  assign w_open       = (r_state == ST_LOCKED) && !fifo_full && !reset;
  assign w_accept     = w_open && req_valid[r_grant];
  assign w_next_ptr   = ID_WIDTH'(rr_next(int'(r_grant), NUM_REQ));

  assign req_ready    = w_open ? (NUM_REQ'(1) << r_grant) : '0;
  assign fifo_wr_en   = w_accept;
  assign fifo_wr_data = req_data[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
  assign grant_id     = r_grant;
  assign busy         = (r_state == ST_LOCKED);

`ifdef ARB_BURST_CHK_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_burst_err;
  logic             w_over;

  assign w_over    = w_accept && !req_last[r_grant] && (r_beat_cnt == CNT_W'(MAX_BURST - 1));
  assign w_end     = w_accept && (req_last[r_grant] || w_over);
  assign burst_err = r_burst_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_cnt  <= '0;
      r_burst_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) r_beat_cnt <= '0;
      else if (w_accept)      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      if (w_over) r_burst_err <= 1'b1;
    end
  end
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (MAX_BURST > 0);
  assign w_end        = w_accept && req_last[r_grant];
  assign burst_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_any_valid) begin
        r_grant <= w_pick;
        r_state <= ST_LOCKED;
      end
    end else if (w_end) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= w_next_ptr;
    end
  end

  always @(posedge clk) begin
    if (!reset) assert (!(fifo_wr_en && fifo_full));
  end

endmodule

// File: tb/tb_tl_fifo_wr_arbiter.sv
// tb/tb_tl_fifo_wr_arbiter.sv - self-checking bench for tl_fifo_wr_arbiter
module tb_tl_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid, req_last, req_ready;
  logic [NR*DW-1:0] req_data;
  logic             fifo_wr_en, fifo_full, busy, burst_err;
  logic [DW-1:0]    fifo_wr_data;
  logic [1:0]       grant_id;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0]  srcq[NR][$];
  logic [10:0] wr_log[$];
  bit          gap_en;

  logic          s_wr_en, s_busy, s_err;
  logic [DW-1:0] s_data;
  logic [NR-1:0] s_ready;
  logic [1:0]    s_grant;

  always #5 clk = ~clk;

  tl_fifo_wr_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(8), .ID_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full), .grant_id(grant_id),
    .busy(busy), .burst_err(burst_err)
  );

  // Sources retire their head beat on a handshake; the FIFO side is logged.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && req_ready[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      if (fifo_wr_en) wr_log.push_back({grant_id, req_last[grant_id], fifo_wr_data});
    end
  end

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (srcq[i].size() > 0 && !(gap_en && $urandom_range(0, 4) == 0)) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = srcq[i][0][7:0];
        req_last[i]           = srcq[i][0][8];
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'($urandom_range(0, 1));
        req_data[i*DW +: DW]  = 8'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    s_wr_en = fifo_wr_en; s_data = fifo_wr_data; s_ready = req_ready;
    s_busy  = busy;       s_grant = grant_id;    s_err = burst_err;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; fifo_full = 1'b0; gap_en = 1'b0;
    for (int i = 0; i < NR; i++) srcq[i].delete();
    tick(); tick();
    reset = 1'b0;
    wr_log.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; fifo_full = 1'b0; gap_en = 1'b0;
    for (int i = 0; i < NR; i++) srcq[i].push_back({1'b1, 8'(i)});
    tick(); tick();
    if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", s_ready); end n_cmp++;
    if (s_wr_en !== 1'b0)    begin n_fail++; $display("FAIL reset_wr_en got %b want 0", s_wr_en); end n_cmp++;
    if (s_busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", s_busy); end n_cmp++;
    if (s_grant !== 2'd0)    begin n_fail++; $display("FAIL reset_grant got %0d want 0", s_grant); end n_cmp++;
    if (s_err !== 1'b0)      begin n_fail++; $display("FAIL reset_err got %b want 0", s_err); end n_cmp++;
    for (int i = 0; i < NR; i++) srcq[i].delete();
    reset = 1'b0;
  endtask

  task automatic test_two_single();
    logic [4:0] we = 5'b01010;
    do_reset();
    srcq[0].push_back({1'b1, 8'h30});
    srcq[2].push_back({1'b1, 8'h32});
    for (int c = 0; c < 5; c++) begin
      tick();
      if (s_wr_en !== we[c]) begin n_fail++; $display("FAIL two_single_we c%0d got %b want %b", c, s_wr_en, we[c]); end n_cmp++;
      if (s_busy !== we[c])  begin n_fail++; $display("FAIL two_single_busy c%0d got %b want %b", c, s_busy, we[c]); end n_cmp++;
      if (we[c]) begin
        if (s_data !== ((c == 1) ? 8'h30 : 8'h32)) begin n_fail++; $display("FAIL two_single_data c%0d got %h", c, s_data); end n_cmp++;
        if (s_grant !== ((c == 1) ? 2'd0 : 2'd2)) begin n_fail++; $display("FAIL two_single_grant c%0d got %0d", c, s_grant); end n_cmp++;
      end
    end
  endtask

  task automatic test_burst_hold();
    logic [5:0]    we = 6'b101110;
    logic [7:0]    dat [6] = '{8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h33};
    logic [NR-1:0] rdy [6] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000};
    do_reset();
    srcq[1].push_back({1'b0, 8'hA1}); srcq[1].push_back({1'b0, 8'hA2}); srcq[1].push_back({1'b1, 8'hA3});
    srcq[3].push_back({1'b1, 8'h33});
    for (int c = 0; c < 6; c++) begin
      tick();
      if (s_wr_en !== we[c])  begin n_fail++; $display("FAIL burst_hold_we c%0d got %b want %b", c, s_wr_en, we[c]); end n_cmp++;
      if (s_ready !== rdy[c]) begin n_fail++; $display("FAIL burst_hold_ready c%0d got %b want %b", c, s_ready, rdy[c]); end n_cmp++;
      if (we[c] && s_data !== dat[c]) begin n_fail++; $display("FAIL burst_hold_data c%0d got %h want %h", c, s_data, dat[c]); end
      if (we[c]) n_cmp++;
    end
  endtask

  task automatic test_full_stall();
    logic [7:0] we = 8'b11000010;
    do_reset();
    srcq[0].push_back({1'b0, 8'h10}); srcq[0].push_back({1'b0, 8'h11}); srcq[0].push_back({1'b1, 8'h12});
    for (int c = 0; c < 8; c++) begin
      fifo_full = (c >= 2 && c <= 5);
      tick();
      if (s_wr_en !== we[c]) begin n_fail++; $display("FAIL full_stall_we c%0d got %b want %b", c, s_wr_en, we[c]); end n_cmp++;
      if (s_ready !== (we[c] ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL full_stall_ready c%0d got %b", c, s_ready); end n_cmp++;
    end
    fifo_full = 1'b0;
    if (wr_log.size() != 3) begin n_fail++; $display("FAIL full_stall_count got %0d want 3", wr_log.size()); end n_cmp++;
    for (int j = 0; j < wr_log.size() && j < 3; j++) begin
      if (wr_log[j][7:0] !== 8'(8'h10 + j)) begin n_fail++; $display("FAIL full_stall_order %0d got %h want %h", j, wr_log[j][7:0], 8'h10 + j); end n_cmp++;
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int k = 0; k < 4; k++) srcq[2].push_back({k == 3, 8'(8'h20 + k)});
    tick(); tick();
    if (s_wr_en !== 1'b1 || s_data !== 8'h20) begin n_fail++; $display("FAIL rst_mid_first got we=%b d=%h want 1/20", s_wr_en, s_data); end n_cmp++;
    srcq[0].push_back({1'b1, 8'h40}); srcq[1].push_back({1'b1, 8'h41});
    reset = 1'b1;
    tick();
    if (s_wr_en !== 1'b0)    begin n_fail++; $display("FAIL rst_mid_we got %b want 0", s_wr_en); end n_cmp++;
    if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_ready got %b want 0000", s_ready); end n_cmp++;
    reset = 1'b0;
    srcq[2].delete();
    tick();
    if (s_busy !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", s_busy); end n_cmp++;
    if (s_grant !== 2'd0) begin n_fail++; $display("FAIL rst_mid_grant got %0d want 0", s_grant); end n_cmp++;
    tick();
    if (s_wr_en !== 1'b1 || s_grant !== 2'd0 || s_data !== 8'h40) begin
      n_fail++; $display("FAIL rst_mid_restart got we=%b g=%0d d=%h want 1/0/40", s_wr_en, s_grant, s_data);
    end n_cmp++;
    if (wr_log.size() != 2) begin n_fail++; $display("FAIL rst_mid_log got %0d writes want 2", wr_log.size()); end n_cmp++;
  endtask

  task automatic test_fairness();
    int cnt [NR];
    do_reset();
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 0;
      for (int k = 0; k < 3; k++) srcq[i].push_back({1'b1, 8'(8'h80 + i*16 + k)});
    end
    for (int c = 0; c < 26; c++) tick();
    if (wr_log.size() != 12) begin n_fail++; $display("FAIL fair_count got %0d want 12", wr_log.size()); end n_cmp++;
    for (int j = 0; j < wr_log.size(); j++) begin
      if (int'(wr_log[j][10:9]) != j % NR) begin n_fail++; $display("FAIL fair_seq %0d got %0d want %0d", j, wr_log[j][10:9], j % NR); end n_cmp++;
      cnt[wr_log[j][10:9]]++;
    end
    for (int i = 0; i < NR; i++) begin
      if (cnt[i] != 3) begin n_fail++; $display("FAIL fair_grants req%0d got %0d want 3", i, cnt[i]); end n_cmp++;
    end
  endtask

  task automatic test_burst_limit();
    logic [10:0] exp_q[$];
    logic        err8, err9, exp9;
    do_reset();
    for (int k = 0; k < 10; k++) srcq[2].push_back({k == 9, 8'(8'h50 + k)});
    srcq[3].push_back({1'b1, 8'h60});
`ifdef ARB_BURST_CHK_EN
    exp9 = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back({2'd2, 1'b0, 8'(8'h50 + k)});
    exp_q.push_back({2'd3, 1'b1, 8'h60});
    exp_q.push_back({2'd2, 1'b0, 8'h58});
    exp_q.push_back({2'd2, 1'b1, 8'h59});
`else
    exp9 = 1'b0;
    for (int k = 0; k < 10; k++) exp_q.push_back({2'd2, k == 9, 8'(8'h50 + k)});
    exp_q.push_back({2'd3, 1'b1, 8'h60});
`endif
    err8 = 1'bx; err9 = 1'bx;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (c == 8) err8 = s_err;
      if (c == 9) err9 = s_err;
    end
    if (err8 !== 1'b0)  begin n_fail++; $display("FAIL limit_err_c8 got %b want 0", err8); end n_cmp++;
    if (err9 !== exp9)  begin n_fail++; $display("FAIL limit_err_c9 got %b want %b", err9, exp9); end n_cmp++;
    if (s_err !== exp9) begin n_fail++; $display("FAIL limit_err_sticky got %b want %b", s_err, exp9); end n_cmp++;
    if (wr_log.size() != exp_q.size()) begin n_fail++; $display("FAIL limit_count got %0d want %0d", wr_log.size(), exp_q.size()); end n_cmp++;
    for (int j = 0; j < wr_log.size() && j < exp_q.size(); j++) begin
      if (wr_log[j] !== exp_q[j]) begin n_fail++; $display("FAIL limit_seq %0d got %h want %h", j, wr_log[j], exp_q[j]); end n_cmp++;
    end
    do_reset();
    tick();
    if (s_err !== 1'b0) begin n_fail++; $display("FAIL limit_err_cleared got %b want 0", s_err); end n_cmp++;
  endtask

  task automatic test_random();
    int owner, ptr, left, c;
    logic [1:0]    m_grant;
    logic [NR-1:0] e_ready;
    logic          e_we, found;
    do_reset();
    owner = -1; ptr = 0; m_grant = 2'd0;
    for (int i = 0; i < NR; i++) begin
      int nb = $urandom_range(2, 5);
      for (int b = 0; b < nb; b++) begin
        int len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) srcq[i].push_back({k == len - 1, 8'($urandom_range(0, 255))});
      end
    end
    c = 0;
    do begin
      gap_en    = (c < 400);
      fifo_full = (c < 400) && ($urandom_range(0, 3) == 0);
      tick();
      e_ready = '0; e_we = 1'b0;
      if (owner >= 0) begin
        e_ready[owner] = !fifo_full;
        e_we = req_valid[owner] && !fifo_full;
      end
      if (s_ready !== e_ready)        begin n_fail++; $display("FAIL rand_ready t%0d got %b want %b", c, s_ready, e_ready); end n_cmp++;
      if (s_wr_en !== e_we)           begin n_fail++; $display("FAIL rand_we t%0d got %b want %b", c, s_wr_en, e_we); end n_cmp++;
      if (s_busy !== (owner >= 0))    begin n_fail++; $display("FAIL rand_busy t%0d got %b want %b", c, s_busy, owner >= 0); end n_cmp++;
      if (s_grant !== m_grant)        begin n_fail++; $display("FAIL rand_grant t%0d got %0d want %0d", c, s_grant, m_grant); end n_cmp++;
      if (e_we) begin
        if (s_data !== req_data[owner*DW +: DW]) begin n_fail++; $display("FAIL rand_data t%0d got %h want %h", c, s_data, req_data[owner*DW +: DW]); end n_cmp++;
      end
      if (owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < NR; k++) begin
          int j = (ptr + k) % NR;
          if (!found && req_valid[j]) begin owner = j; m_grant = 2'(j); found = 1'b1; end
        end
      end else if (e_we && req_last[owner]) begin
        ptr = (owner + 1) % NR;
        owner = -1;
      end
      left = 0;
      for (int i = 0; i < NR; i++) left += srcq[i].size();
      c++;
    end while (c < 1000 && !(c >= 400 && left == 0 && owner < 0));
    if (left != 0) begin n_fail++; $display("FAIL rand_drain got %0d beats left want 0", left); end n_cmp++;
  endtask

  initial begin
    reset = 1'b1; fifo_full = 1'b0; gap_en = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    test_reset();
    test_two_single();
    test_burst_hold();
    test_full_stall();
    test_reset_mid_burst();
    test_fairness();
    test_burst_limit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
